bist_read_checker: RTL and testbench
====================================

# bist_read_checker

Read-side counterpart of the BIST memory write path. It sweeps every address of a memory under test and drives the read address and read enable. It captures the returned read data after a fixed latency and compares each word against the pattern the BIST writer loaded. It reports pass/fail, an error count, and the first failing address and data; it sits between the BIST controller and the memory read port.

## Interface

Parameters:
- RWIDTH, 34, data word width; must be >= RDEPTH.
- RDEPTH, 14, address width; the sweep covers 2^RDEPTH words.
- RD_LAT, 1, memory read latency in cycles, legal range 1..4.
- CNTW, 16, error counter width.

Ports:
- CLK_i, input, 1, single clock; all logic is on the rising edge.
- RSTN_i, input, 1, asynchronous active-low reset.
- START_i, input, 1, starts a sweep; sampled only in IDLE.
- PATTERN_i, input, 2, expected-data select; sampled with START_i and held internally for the whole sweep.
- OA_o, output, RDEPTH, registered read address.
- RE_o, output, 1, registered read enable.
- O_i, input, RWIDTH, memory read data.
- BUSY_o, output, 1, sweep in progress.
- DONE_o, output, 1, one-cycle completion pulse.
- FAIL_o, output, 1, set on any mismatch; sticky until the next start.
- ERRCNT_o, output, CNTW, mismatch count; saturates at all-ones.
- FAILADDR_o, output, RDEPTH, address of the first mismatch.
- FAILDATA_o, output, RWIDTH, read data of the first mismatch.

## Operation

States:
- IDLE: wait for START_i.
- READ: issue one read per cycle, 2^RDEPTH reads in total.
- DRAIN: wait RD_LAT cycles for the last read data.
- DONE: one cycle, then back to IDLE.

Transitions:
- IDLE -> READ when START_i = 1. On the same edge: latch PATTERN_i, clear FAIL_o, ERRCNT_o, FAILADDR_o and FAILDATA_o, and set OA_o = 0 and RE_o = 1.
- READ: OA_o increments by 1 each cycle. After address 2^RDEPTH-1 has been issued, RE_o = 0, OA_o holds its value, and the FSM enters DRAIN.
- DRAIN -> DONE after the last compare.
- DONE -> IDLE after one cycle.

Read pipeline:
- A shift register RD_LAT deep carries a valid bit and the address of each issued read.
- When a valid entry emerges, O_i is compared against expected(addr).

Expected data, with addr the read address:
- PATTERN 00: all zeros.
- PATTERN 01: all ones.
- PATTERN 10: checkerboard. Even addresses expect bits alternating 1,0 from LSB (0x55.. pattern). Odd addresses expect the bitwise inverse (0xAA..).
- PATTERN 11: addr zero-extended to RWIDTH.

On a mismatch:
- ERRCNT_o increments, unless already all-ones; then it holds.
- FAIL_o is set.
- If FAIL_o was previously 0, FAILADDR_o and FAILDATA_o capture addr and O_i.

Boundary behaviour:
- START_i outside IDLE is ignored, including in the DONE cycle.
- Results hold after DONE until the next accepted start.
- Asserting RSTN_i mid-sweep aborts immediately. State returns to IDLE, the pipeline is flushed, and any read in flight is discarded.
- PATTERN_i changes during a sweep have no effect.

## Timing

Reset values: every output is 0 (OA_o, RE_o, BUSY_o, DONE_o, FAIL_o, ERRCNT_o, FAILADDR_o, FAILDATA_o).

Cycle numbering starts at the START_i sampling edge (cycle 0); N = 2^RDEPTH.
- Cycles 1..N: RE_o = 1, with OA_o = k in cycle k+1.
- Read data for address k is sampled on the edge ending cycle k+1+RD_LAT.
- The compare result (ERRCNT_o, FAIL_o, FAILADDR_o, FAILDATA_o) is visible in the following cycle.
- The last compare occurs on the edge ending cycle N+RD_LAT.
- BUSY_o = 1 in cycles 1..N+RD_LAT.
- DONE_o = 1 only in cycle N+RD_LAT+1. In that cycle BUSY_o = 0 and all results are final.
- A new START_i is accepted at the earliest in cycle N+RD_LAT+2.
- Throughput is one word per cycle with no bubbles.

## Test plan

Bench configuration: RWIDTH=8, RDEPTH=4, RD_LAT=2, CNTW=16, using a memory model with 2-cycle read latency.

1. Reset: hold RSTN_i=0 with random inputs -> every output is 0. Release reset -> outputs stay 0 while START_i=0.
2. Clean run: memory all 0x00, PATTERN=00, START pulse -> RE_o high for exactly 16 cycles with OA_o = 0..15. DONE_o pulses in cycle 19. FAIL_o=0, ERRCNT_o=0.
3. Address pattern with faults: memory = address, except address 5 returns 0x15 and address 9 returns 0x00; PATTERN=11 -> ERRCNT_o=2, FAIL_o=1, FAILADDR_o=5, FAILDATA_o=0x15.
4. Checkerboard: memory all 0x55, PATTERN=10 -> ERRCNT_o=8, FAILADDR_o=1, FAILDATA_o=0x55.
5. Control abuse: START_i pulses in cycles 3 and 19 -> both ignored, a single sweep runs, and DONE_o pulses only in cycle 19. Second run: assert RSTN_i=0 while OA_o=7 -> all outputs 0 immediately. Release and START with memory all ones, PATTERN=01 -> clean full sweep, ERRCNT_o=0.
6. Saturation (rebuild with CNTW=3): memory all 0x00, PATTERN=01 -> ERRCNT_o counts to 7 and holds at 7. FAILADDR_o=0, FAILDATA_o=0x00.

Source files
------------

// File: rtl/bist_read_checker.sv
// bist_read_checker
//   Read side of the memory BIST. It sweeps all 2^RDEPTH addresses, one read per
//   cycle. Each returned word is checked RD_LAT cycles later against the pattern
//   the writer loaded. Pass/fail, a saturating error count and the first failing
//   address/data are reported.
//
// Ports
//   CLK_i, RSTN_i        clock, async active-low reset
//   START_i, PATTERN_i   sweep request and pattern select (both sampled in IDLE)
//   OA_o, RE_o           registered read address / read enable to the memory
//   O_i                  memory read data
//   BUSY_o, DONE_o       sweep in progress / one-cycle completion pulse
//   FAIL_o, ERRCNT_o     sticky mismatch flag, saturating mismatch count
//   FAILADDR_o/DATA_o    address and data of the first mismatch
module bist_read_checker #(
   parameter int RWIDTH = 34,
   parameter int RDEPTH = 14,
   parameter int RD_LAT = 1,
   parameter int CNTW   = 16
) (
   input  logic              CLK_i,
   input  logic              RSTN_i,
   input  logic              START_i,
   input  logic [1:0]        PATTERN_i,
   output logic [RDEPTH-1:0] OA_o,
   output logic              RE_o,
   input  logic [RWIDTH-1:0] O_i,
   output logic              BUSY_o,
   output logic              DONE_o,
   output logic              FAIL_o,
   output logic [CNTW-1:0]   ERRCNT_o,
   output logic [RDEPTH-1:0] FAILADDR_o,
   output logic [RWIDTH-1:0] FAILDATA_o
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   // 0x55.. word: bit i is 1 for even i
   function automatic logic [RWIDTH-1:0] f_chk();
      logic [RWIDTH-1:0] v;
      for (int i = 0; i < RWIDTH; i++) v[i] = ((i % 2) == 0);
      return v;
   endfunction
   localparam logic [RWIDTH-1:0] CHK = f_chk();

   state_t                         r_state;
   logic [2:0]                     r_dcnt;
   logic [1:0]                     r_pat;
   logic [RD_LAT-1:0]              r_pv;
   logic [RD_LAT-1:0][RDEPTH-1:0]  r_pa;

   logic                           w_start;
   logic                           w_vld;
   logic [RDEPTH-1:0]              w_addr;
   logic [RWIDTH-1:0]              w_exp;

   assign w_start = (r_state == S_IDLE) && START_i;
   assign w_vld   = r_pv[RD_LAT-1];
   assign w_addr  = r_pa[RD_LAT-1];

   always_comb begin
      w_exp = '0;
      case (r_pat)
         2'b00: w_exp = '0;
         2'b01: w_exp = '1;
         2'b10: w_exp = w_addr[0] ? ~CHK : CHK;
         2'b11: w_exp = RWIDTH'(w_addr);
         default: w_exp = '0;
      endcase
   end

   // Sweep control FSM
   always_ff @(posedge CLK_i or negedge RSTN_i) begin
      if (!RSTN_i) begin
         r_state <= S_IDLE;
         r_dcnt  <= '0;
         r_pat   <= '0;
         OA_o    <= '0;
         RE_o    <= 1'b0;
         BUSY_o  <= 1'b0;
         DONE_o  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               DONE_o <= 1'b0;
               if (START_i) begin
                  r_state <= S_READ;
                  r_pat   <= PATTERN_i;
                  OA_o    <= '0;
                  RE_o    <= 1'b1;
                  BUSY_o  <= 1'b1;
               end
            end
            S_READ: begin
               if (OA_o == '1) begin
                  // last address issued; OA_o holds, wait for data in flight
                  RE_o    <= 1'b0;
                  r_dcnt  <= '0;
                  r_state <= S_DRAIN;
               end else begin
                  OA_o <= OA_o + 1'b1;
               end
            end
            S_DRAIN: begin
               if (r_dcnt == 3'(RD_LAT - 1)) begin
                  r_state <= S_DONE;
                  BUSY_o  <= 1'b0;
                  DONE_o  <= 1'b1;
               end else begin
                  r_dcnt <= r_dcnt + 1'b1;
               end
            end
            S_DONE: begin
               DONE_o  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Read-latency pipeline and result capture
   always_ff @(posedge CLK_i or negedge RSTN_i) begin
      if (!RSTN_i) begin
         r_pv       <= '0;
         r_pa       <= '0;
         FAIL_o     <= 1'b0;
         ERRCNT_o   <= '0;
         FAILADDR_o <= '0;
         FAILDATA_o <= '0;
      end else begin
         r_pv[0] <= RE_o;
         r_pa[0] <= OA_o;
         for (int i = 1; i < RD_LAT; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pa[i] <= r_pa[i-1];
         end
         if (w_start) begin
            FAIL_o     <= 1'b0;
            ERRCNT_o   <= '0;
            FAILADDR_o <= '0;
            FAILDATA_o <= '0;
         end else if (w_vld && (O_i != w_exp)) begin
            FAIL_o <= 1'b1;
            if (ERRCNT_o != '1) ERRCNT_o <= ERRCNT_o + 1'b1;
            if (!FAIL_o) begin
               FAILADDR_o <= w_addr;
               FAILDATA_o <= O_i;
            end
         end
      end
   end

endmodule

// File: tb/tb_bist_read_checker.sv
module tb_bist_read_checker;

   localparam int N   = 16;
   localparam int LAT = 2;

   typedef struct {
      int         s0;
      logic [15:0] errcnt;
      logic        fail;
      logic [3:0]  addr;
      logic [7:0]  data;
      logic [2:0]  errcnt3;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  pattern = 2'b00;
   logic [7:0]  odata;
   logic [3:0]  oa;
   logic        re, busy, done, fail;
   logic [15:0] errcnt;
   logic [3:0]  faddr;
   logic [7:0]  fdata;
   // second instance with a 3-bit counter for saturation
   logic [3:0]  oa2;
   logic        re2, busy2, done2, fail2;
   logic [2:0]  errcnt2;
   logic [3:0]  faddr2;
   logic [7:0]  fdata2;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   exp_t sbq[$];

   logic [7:0] mem [N];
   logic [7:0] m_a1, m_d;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // 2-cycle read latency memory model
   always @(posedge clk) begin
      m_a1 <= mem[oa];
      m_d  <= m_a1;
   end
   assign odata = m_d;

   bist_read_checker #(.RWIDTH(8), .RDEPTH(4), .RD_LAT(LAT), .CNTW(16)) dut (
      .CLK_i(clk), .RSTN_i(rstn), .START_i(start), .PATTERN_i(pattern),
      .OA_o(oa), .RE_o(re), .O_i(odata), .BUSY_o(busy), .DONE_o(done),
      .FAIL_o(fail), .ERRCNT_o(errcnt), .FAILADDR_o(faddr), .FAILDATA_o(fdata));

   bist_read_checker #(.RWIDTH(8), .RDEPTH(4), .RD_LAT(LAT), .CNTW(3)) dut3 (
      .CLK_i(clk), .RSTN_i(rstn), .START_i(start), .PATTERN_i(pattern),
      .OA_o(oa2), .RE_o(re2), .O_i(odata), .BUSY_o(busy2), .DONE_o(done2),
      .FAIL_o(fail2), .ERRCNT_o(errcnt2), .FAILADDR_o(faddr2), .FAILDATA_o(fdata2));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // Monitor: tracks the read stream, pops an expectation at each DONE pulse
   int re_cnt = 0, oa_exp = 0, oa_bad = 0;
   always @(negedge clk) begin
      if (!rstn) begin
         re_cnt = 0; oa_exp = 0; oa_bad = 0;
      end else begin
         if (re) begin
            if (int'(oa) != oa_exp) oa_bad++;
            oa_exp++;
            re_cnt++;
         end
         if (done) begin
            if (sbq.size() == 0) begin
               chk("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("re_cycles", 64'(re_cnt), 64'(N));
               chk("oa_sequence_errs", 64'(oa_bad), 64'd0);
               chk("done_cycle", 64'(cyc - e.s0), 64'(N + LAT + 1));
               chk("busy_at_done", 64'(busy), 64'd0);
               chk("errcnt", 64'(errcnt), 64'(e.errcnt));
               chk("fail", 64'(fail), 64'(e.fail));
               chk("failaddr", 64'(faddr), 64'(e.addr));
               chk("faildata", 64'(fdata), 64'(e.data));
               chk("errcnt_sat3", 64'(errcnt2), 64'(e.errcnt3));
            end
            re_cnt = 0; oa_exp = 0; oa_bad = 0;
         end
      end
   end

   task automatic go_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic fill(input logic [7:0] v);
      for (int i = 0; i < N; i++) mem[i] = v;
   endtask

   // Pulses START in cycle 0 (returns s0 = cycle-0 count); PATTERN is then
   // scrambled to show the sweep ignores it.
   task automatic start_run(input logic [1:0] pat, input bit push, input exp_t e, output int s0);
      @(negedge clk);
      pattern = pat;
      start = 1'b1;
      s0 = cyc;
      e.s0 = cyc;
      if (push) sbq.push_back(e);
      @(negedge clk);
      start = 1'b0;
      pattern = ~pat;
   endtask

   function automatic exp_t mk(input logic [15:0] ec, input logic f, input logic [3:0] a,
                               input logic [7:0] d, input logic [2:0] ec3);
      exp_t e;
      e.s0 = 0; e.errcnt = ec; e.fail = f; e.addr = a; e.data = d; e.errcnt3 = ec3;
      return e;
   endfunction

   function automatic logic [63:0] all_out();
      return 64'({oa, re, busy, done, fail, errcnt, faddr, fdata, errcnt2});
   endfunction

   initial begin
      int s0;
      int n;

      // 1. reset with random inputs
      for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         start = 1'($urandom);
         pattern = 2'($urandom);
      end
      chk("reset_outputs", all_out(), 64'd0);
      start = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_outputs", all_out(), 64'd0);

      // 2. clean run, all zeros
      fill(8'h00);
      start_run(2'b00, 1, mk(16'd0, 1'b0, 4'd0, 8'h00, 3'd0), s0);
      go_to(s0 + N + LAT + 4);

      // 3. address pattern with two faults
      for (int i = 0; i < N; i++) mem[i] = 8'(i);
      mem[5] = 8'h15;
      mem[9] = 8'h00;
      start_run(2'b11, 1, mk(16'd2, 1'b1, 4'd5, 8'h15, 3'd2), s0);
      go_to(s0 + N + LAT + 4);

      // 4. checkerboard against all-0x55: every odd address fails
      fill(8'h55);
      start_run(2'b10, 1, mk(16'd8, 1'b1, 4'd1, 8'h55, 3'd7), s0);
      go_to(s0 + N + LAT + 4);

      // 5. START abuse during the sweep and in the DONE cycle
      fill(8'h00);
      start_run(2'b00, 1, mk(16'd0, 1'b0, 4'd0, 8'h00, 3'd0), s0);
      go_to(s0 + 3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      go_to(s0 + N + LAT + 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_in_done_ignored", 64'(busy), 64'd0);
      go_to(s0 + N + LAT + 5);
      chk("results_hold", 64'({fail, errcnt, busy}), 64'd0);

      // abort mid-sweep with reset
      fill(8'hFF);
      start_run(2'b00, 0, mk(16'd0, 1'b0, 4'd0, 8'h00, 3'd0), s0);
      n = 0;
      while (oa != 4'd7 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("reached_oa7", 64'(n < 40), 64'd1);
      rstn = 1'b0;
      #1;
      chk("abort_outputs", all_out(), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      chk("after_abort_idle", all_out(), 64'd0);
      start_run(2'b01, 1, mk(16'd0, 1'b0, 4'd0, 8'h00, 3'd0), s0);
      go_to(s0 + N + LAT + 4);

      // 6. counter saturation: all zeros vs all-ones pattern
      fill(8'h00);
      start_run(2'b01, 1, mk(16'd16, 1'b1, 4'd0, 8'h00, 3'd7), s0);
      go_to(s0 + 9);
      chk("sat_errcnt_6", 64'(errcnt2), 64'd6);
      go_to(s0 + 10);
      chk("sat_errcnt_7", 64'(errcnt2), 64'd7);
      go_to(s0 + 14);
      chk("sat_errcnt_hold", 64'(errcnt2), 64'd7);
      chk("wide_errcnt_mid", 64'(errcnt), 64'd11);
      go_to(s0 + N + LAT + 4);

      chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
